dbg_host_link: RTL and testbench

//   Host-side initiator for the debugger command interface (host_cmd/host_param/host_cmd_en/host_result).

---
 rtl/dbg_host_link.sv | 123 ++++++++++++
 tb/tb_dbg_host_link.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_host_link.sv
// Host-side command bridge: parses UART RX bytes into debugger command frames,
// strobes each command to the controller, and streams the 32-bit result back over TX.
module dbg_host_link #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  host_cmd,
  output logic [31:0] host_param,
  output logic        host_cmd_en,
  input  logic [31:0] host_result,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_ISSUE,
    S_CAPTURE,
    S_SEND
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  shadow_cmd;
  logic [31:0] shadow_param;
  logic [1:0]  idx;
  logic [1:0]  k;
  logic [31:0] gap_cnt;
  logic [31:0] resp;
  logic        rx_fire, tx_fire, timeout_hit;

  assign rx_fire     = rx_valid & rx_ready;
  assign tx_fire     = tx_valid & tx_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (gap_cnt == TIMEOUT_CYCLES - 32'd1);

  // Strobes decode straight from state so an async reset drops them at once.
  assign rx_ready    = (state == S_IDLE) || (state == S_PARAM);
  assign host_cmd_en = (state == S_ISSUE);
  assign tx_valid    = (state == S_SEND);
  assign busy        = (state != S_IDLE);
  assign tx_data     = tx_valid ? resp[8*k +: 8] : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (rx_fire) state_nxt = rx_data[7] ? S_PARAM : S_ISSUE;
      S_PARAM: begin
        if (rx_fire) begin
          if (idx == 2'd3) state_nxt = S_ISSUE;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_SEND;
      S_SEND:    if (tx_fire && k == 2'd3) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_cmd   <= 8'h00;
      shadow_param <= 32'h0;
      idx          <= 2'd0;
      k            <= 2'd0;
      gap_cnt      <= 32'h0;
      resp         <= 32'h0;
      host_cmd     <= 8'h00;
      host_param   <= 32'h0;
    end else begin
      gap_cnt <= 32'h0;
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            shadow_cmd   <= rx_data;
            shadow_param <= 32'h0;
            idx          <= 2'd0;
            // Parameterless commands go straight to ISSUE, so load the outputs on this edge.
            if (!rx_data[7]) begin
              host_cmd   <= rx_data;
              host_param <= 32'h0;
            end
          end
        end
        S_PARAM: begin
          if (rx_fire) begin
            shadow_param[8*idx +: 8] <= rx_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              host_cmd   <= shadow_cmd;
              host_param <= {rx_data, shadow_param[23:0]};
            end
          end else if (!timeout_hit) begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        S_CAPTURE: begin
          resp <= host_result;
          k    <= 2'd0;
        end
        S_SEND: begin
          if (tx_fire) k <= k + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_host_link.sv
// Scoreboard bench for dbg_host_link: stimulus pushes expected commands and TX bytes,
// monitors pop and compare whenever the DUT strobes a command or hands off a TX byte.
module tb_dbg_host_link;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  host_cmd;
  logic [31:0] host_param;
  logic        host_cmd_en;
  logic [31:0] host_result;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  c;
    logic [31:0] p;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [7:0] tx_q[$];
  logic       en_prev = 1'b0;

  always #5 clk = ~clk;

  dbg_host_link #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .host_cmd    (host_cmd),
    .host_param  (host_param),
    .host_cmd_en (host_cmd_en),
    .host_result (host_result),
    .busy        (busy)
  );

  // Controller model: result is valid only in the cycle after the strobe.
  function automatic logic [31:0] ctrl_fn(input logic [7:0] c, input logic [31:0] p);
    if (c == 8'h0E)                      return 32'h0000_0003;
    if (c == 8'h86 && p == 32'h0000_001F) return 32'hDEAD_BEEF;
    if (c == 8'h85)                      return 32'h0000_0000;
    return {c, p[7:0] ^ 8'h3C, 8'h5A, ~c};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           host_result <= 32'h0;
    else if (host_cmd_en) host_result <= ctrl_fn(host_cmd, host_param);
    else                  host_result <= 32'hA5A5_A5A5;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input logic [7:0] c, input logic [31:0] p);
    cmd_t e;
    logic [31:0] r;
    e.c = c;
    e.p = p;
    cmd_q.push_back(e);
    r = ctrl_fn(c, p);
    for (int i = 0; i < 4; i++) tx_q.push_back(r[8*i +: 8]);
  endtask

  // Monitors: sample on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst_n) begin
      if (host_cmd_en) begin
        check("cmd_en_single_cycle", {31'b0, en_prev}, 32'd0);
        check("rx_ready_during_issue", {31'b0, rx_ready}, 32'd0);
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd_en", 32'd1, 32'd0);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          check("host_cmd", {24'b0, host_cmd}, {24'b0, e.c});
          check("host_param", host_param, e.p);
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          check("unexpected_tx_byte", {24'b0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] b;
          b = tx_q.pop_front();
          check("tx_byte", {24'b0, tx_data}, {24'b0, b});
        end
      end
      en_prev <= host_cmd_en;
    end else begin
      en_prev <= 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_cmd_en_next();
    @(negedge clk);
    check("cmd_en_latency", {31'b0, host_cmd_en}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] p);
    expect_frame(c, p);
    send_byte(c);
    if (c[7]) for (int i = 0; i < 4; i++) send_byte(p[8*i +: 8]);
    check_cmd_en_next();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || tx_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, cmd_q.size() + tx_q.size(), 32'd0);
  endtask

  task automatic wait_tx_valid();
    int n;
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tx_valid_arrives", {31'b0, tx_valid}, 32'd1);
  endtask

  task automatic apply_reset_and_check(input string tag);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_outs"}, {host_cmd_en, tx_valid, host_cmd, tx_data}, 18'h0);
    check({tag, "_param"}, host_param, 32'h0);
    check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd1);
    cmd_q.delete();
    tx_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    // Reset values
    #12;
    check("reset_outs", {host_cmd_en, tx_valid, busy, host_cmd, tx_data}, 19'h0);
    check("reset_param", host_param, 32'h0);
    check("reset_rx_ready", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: parameterless command
    send_frame(8'h0E, 32'h0);
    wait_drain("t1_drain");

    // 2: parameter frame; outputs hold the previous command while assembling
    expect_frame(8'h86, 32'h0000_001F);
    send_byte(8'h86);
    send_byte(8'h1F);
    check("t2_hold_cmd", {24'b0, host_cmd}, 32'h0E);
    check("t2_hold_param", host_param, 32'h0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check_cmd_en_next();
    wait_drain("t2_drain");

    // 3: TX stall holds byte 0 stable
    tx_ready = 1'b0;
    send_frame(8'h85, 32'hBF00_0010);
    wait_tx_valid();
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == 8'h00)) n++;
    end
    check("t3_stall_stable", n, 32'd0);
    tx_ready = 1'b1;
    wait_drain("t3_drain");

    // 4: inter-byte timeout discards the partial frame
    send_byte(8'h86);
    send_byte(8'h01);
    repeat (15) @(posedge clk);
    #1;
    check("t4_busy_before_timeout", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("t4_idle_after_timeout", {busy, rx_ready}, 32'b01);
    send_frame(8'h0A, 32'h0);
    wait_drain("t4_drain");

    // 5: back-to-back frames with rx_valid held high
    expect_frame(8'h01, 32'h0);
    expect_frame(8'h02, 32'h0);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    rx_data = 8'h02;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 50) begin @(negedge clk); n++; end
    check("t5_second_accepted", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    wait_drain("t5_drain");

    // 6: reset during PARAM and during SEND
    send_byte(8'h86);
    send_byte(8'h11);
    apply_reset_and_check("t6_param_rst");
    send_frame(8'h05, 32'h0);
    wait_drain("t6a_drain");
    tx_ready = 1'b0;
    send_frame(8'h07, 32'h0);
    wait_tx_valid();
    apply_reset_and_check("t6_send_rst");
    tx_ready = 1'b1;
    send_frame(8'h8C, 32'h1234_5678);
    wait_drain("t6b_drain");

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
